// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: reset vector, NOP encoding, fetch FSM
// states and the opcode/func values that decode also relies on.
package mips_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } fetch_state_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched word, inserts a bubble, or holds.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    // A bubble leaves pc4 untouched; only instr/valid mark the slot as empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= NOP;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else if (bubble_i) begin
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction fetch: PC select, redirect-during-miss FSM (RUN/PEND),
// saturating cache-stall counter and the IF/ID register.
module if_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [29:0] ic_addr,
    output logic        ic_ren,
    input  logic [31:0] ic_rdata,
    input  logic        ic_stall,
    input  logic        hold,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic [31:0] pc,
    output logic [15:0] stall_cnt
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [31:0]  pc4;
    logic         adv;
    logic         load;
    logic         bubble;

    assign adv = !ic_stall && !hold;
    assign pc4 = pc_q + 32'd4;

    // hold freezes everything; a redirect seen during a miss is parked in
    // pend_pc and applied when the miss resolves, unless a newer one arrives.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        load      = 1'b0;
        bubble    = 1'b0;
        if (adv) begin
            state_d = RUN;
            if (redirect) begin
                pc_d   = word_align(redirect_pc);
                bubble = 1'b1;
            end else if (state_q == PEND) begin
                pc_d   = pend_pc_q;
                bubble = 1'b1;
            end else begin
                pc_d = pc4;
                load = 1'b1;
            end
        end else if (ic_stall && !hold) begin
            bubble = 1'b1;
            if (redirect) begin
                state_d   = PEND;
                pend_pc_d = word_align(redirect_pc);
            end
        end
    end

    assign cnt_d = (ic_stall && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            pend_pc_q <= 32'h0;
            cnt_q     <= 16'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    if_id_reg u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .bubble_i (bubble),
        .instr_i  (ic_rdata),
        .pc4_i    (pc4),
        .instr_o  (id_instr),
        .pc4_o    (id_pc4),
        .valid_o  (id_valid)
    );

    assign ic_addr   = pc_q[31:2];
    assign ic_ren    = !rst;
    assign pc        = pc_q;
    assign stall_cnt = cnt_q;

endmodule
